// File: rtl/scale_seek_if.sv
// Request/response bundle for scale_seek: value request in, resolved scale index out.
interface scale_seek_if;
  logic [31:0] value_in;
  logic        req_valid;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  scale_out;
  logic        exact;
  logic        overflow;

  modport master (
    output value_in, req_valid, resp_ready,
    input  req_ready, resp_valid, scale_out, exact, overflow
  );

  modport slave (
    input  value_in, req_valid, resp_ready,
    output req_ready, resp_valid, scale_out, exact, overflow
  );
endinterface

// File: rtl/scale_seek.sv
// Resolves a time-base value to the smallest scale index whose table code covers it,
// walking the 1-2-5 table one entry per cycle.
//
// state  | meaning
// IDLE   | ready for a request; value latched on req_valid
// SEARCH | compare code(idx) against the latched value, one entry per cycle
// DONE   | result held on outputs until resp_ready
module scale_seek #(
  parameter int NUM_SCALES = 13
) (
  input  logic         clk,
  input  logic         rst,
  scale_seek_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_SCALES - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  scale_q, scale_d;
  logic        exact_q, exact_d;
  logic        overflow_q, overflow_d;
  logic [31:0] code;

  always_comb begin
    case (idx_q)
      4'd0:    code = 32'd1000;
      4'd1:    code = 32'd2000;
      4'd2:    code = 32'd5000;
      4'd3:    code = 32'd10000;
      4'd4:    code = 32'd20000;
      4'd5:    code = 32'd50000;
      4'd6:    code = 32'd100000;
      4'd7:    code = 32'd200000;
      4'd8:    code = 32'd500000;
      4'd9:    code = 32'd1000000;
      4'd10:   code = 32'd2000000;
      4'd11:   code = 32'd5000000;
      default: code = 32'd10000000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    idx_d      = idx_q;
    scale_d    = scale_q;
    exact_d    = exact_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          value_d = bus.value_in;
          idx_d   = 4'd0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (code >= value_q) begin
          scale_d    = idx_q;
          exact_d    = (code == value_q);
          overflow_d = 1'b0;
          state_d    = DONE;
        end else if (idx_q == LAST_IDX) begin
          scale_d    = LAST_IDX;
          exact_d    = 1'b0;
          overflow_d = 1'b1;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      value_q    <= 32'd0;
      idx_q      <= 4'd0;
      scale_q    <= 4'd0;
      exact_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      idx_q      <= idx_d;
      scale_q    <= scale_d;
      exact_q    <= exact_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.scale_out  = scale_q;
  assign bus.exact      = exact_q;
  assign bus.overflow   = overflow_q;

endmodule
